// File: rtl/miniproc_pkg.sv
// miniproc_pkg: port FSM state type, default widths and index-width helper
package miniproc_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} port_state_t;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/dual_port_mem_port_ctrl.sv
// mem_port_ctrl: req/ready/valid handshake, wait-state counter and operand capture for one port
module mem_port_ctrl
  import miniproc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int WAIT   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W/8-1:0] i_wen,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                o_ready,
  output logic                o_valid,
  output logic                o_done,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [DATA_W/8-1:0] o_wen,
  output logic [DATA_W-1:0]   o_wdata
);
  localparam logic [3:0] WAIT_M1 = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
  port_state_t         r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W/8-1:0] r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_valid;
  logic                w_busy, w_accept;
  assign w_busy   = r_state == ST_BUSY;
  assign o_ready  = ~reset & ~w_busy;
  assign w_accept = i_req & o_ready;
  // completion is the accepting edge itself with no wait states, else the edge the counter expires
  assign o_done   = (w_accept & (WAIT == 0)) | (w_busy & (r_cnt == 4'd0));
  assign o_addr   = w_busy ? r_addr : i_addr;
  assign o_wen    = w_busy ? r_wen : i_wen;
  assign o_wdata  = w_busy ? r_wdata : i_wdata;
  assign o_valid  = r_valid;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wen   <= '0;
      r_wdata <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= o_done;
      if (w_accept) begin
        r_state <= (WAIT == 0) ? ST_RESP : ST_BUSY;
        r_cnt   <= WAIT_M1;
        r_addr  <= i_addr;
        r_wen   <= i_wen;
        r_wdata <= i_wdata;
      end else if (w_busy) begin
        r_state <= (r_cnt == 4'd0) ? ST_RESP : ST_BUSY;
        r_cnt   <= r_cnt - 4'd1;
      end else begin
        r_state <= ST_IDLE;
      end
    end
endmodule

// File: rtl/dual_port_mem.sv
// dual_port_mem: shared instruction/data RAM with per-port wait states and byte-enable writes.
// Define DPMEM_RANGE_CHECK_EN to flag out-of-range accesses (d_err) instead of wrapping the index.
module dual_port_mem
  import miniproc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 1024,
  parameter int WAIT   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic                i_valid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_wen,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ready,
  output logic                d_valid,
`ifdef DPMEM_RANGE_CHECK_EN
  output logic                d_err,
`endif
  output logic [DATA_W-1:0]   d_rdata
);
  localparam int BW  = DATA_W / 8;
  localparam int OFF = idx_w(BW);
  localparam int IW  = idx_w(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_i_done, w_d_done, w_i_oor, w_d_oor, w_d_we, w_unused;
  logic [ADDR_W-1:0] w_i_addr, w_d_addr;
  logic [BW-1:0]     w_i_wen, w_d_wen;
  logic [DATA_W-1:0] w_i_wdata, w_d_wdata;
  logic [IW-1:0]     w_i_idx, w_d_idx;
  mem_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT(WAIT)) u_iport (
    .clk(clk), .reset(reset), .i_req(i_req), .i_addr(i_addr), .i_wen('0), .i_wdata('0),
    .o_ready(i_ready), .o_valid(i_valid), .o_done(w_i_done),
    .o_addr(w_i_addr), .o_wen(w_i_wen), .o_wdata(w_i_wdata)
  );
  mem_port_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT(WAIT)) u_dport (
    .clk(clk), .reset(reset), .i_req(d_req), .i_addr(d_addr), .i_wen(d_wen), .i_wdata(d_wdata),
    .o_ready(d_ready), .o_valid(d_valid), .o_done(w_d_done),
    .o_addr(w_d_addr), .o_wen(w_d_wen), .o_wdata(w_d_wdata)
  );
  assign w_i_idx = w_i_addr[OFF +: IW];
  assign w_d_idx = w_d_addr[OFF +: IW];
`ifdef DPMEM_RANGE_CHECK_EN
  assign w_i_oor = |w_i_addr[ADDR_W-1:OFF+IW];
  assign w_d_oor = |w_d_addr[ADDR_W-1:OFF+IW];
`else
  assign w_i_oor = 1'b0;
  assign w_d_oor = 1'b0;
`endif
  assign w_d_we   = w_d_done & (|w_d_wen) & ~w_d_oor;
  assign w_unused = ^{w_i_addr, w_d_addr, w_i_wen, w_i_wdata};
  // both reads sample the array before this edge's write lands: read-before-write and old-data collisions
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (w_i_done) i_rdata <= w_i_oor ? '0 : r_mem[w_i_idx];
      if (w_d_done) d_rdata <= w_d_oor ? '0 : r_mem[w_d_idx];
    end
`ifdef DPMEM_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) d_err <= 1'b0;
    else d_err <= w_d_done & w_d_oor;
`endif
  always_ff @(posedge clk)
    if (w_d_we)
      for (int b = 0; b < BW; b++)
        if (w_d_wen[b]) r_mem[w_d_idx][8*b +: 8] <= w_d_wdata[8*b +: 8];
endmodule

// File: doc/dual_port_mem.md
# dual_port_mem

Parametrised dual-port RAM that replaces the separate instruction and data memories with one shared array. The instruction port is read-only and the data port is read/write with byte enables. Each port has a req/ready/valid handshake and a configurable number of wait states, so the processor can be exercised against slow memory. The block sits between the processor core and the top level, or bench, on the core clock.

## Interface
Parameters:
- DATA_W, 32: word width in bits; multiple of 8.
- ADDR_W, 32: byte-address width.
- DEPTH, 1024: number of words; power of two.
- WAIT, 0: wait states per access; range 0..15.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction read request.
- i_addr  in  ADDR_W  instruction byte address.
- i_ready  out  1  instruction port can accept a request.
- i_valid  out  1  i_rdata is valid; one-cycle pulse.
- i_rdata  out  DATA_W  instruction word.
- d_req  in  1  data request.
- d_addr  in  ADDR_W  data byte address.
- d_wen  in  DATA_W/8  byte write enables; all zero means read.
- d_wdata  in  DATA_W  write data.
- d_ready  out  1  data port can accept a request.
- d_valid  out  1  d_rdata valid / write done; one-cycle pulse.
- d_rdata  out  DATA_W  read data.
- d_err  out  1  out-of-range access; only present with DPMEM_RANGE_CHECK_EN.

## Operation
- Word index = addr >> log2(DATA_W/8). The low byte-offset bits are ignored.
- The two ports are independent. Each has a three-state FSM:
  - IDLE → BUSY: on acceptance, when WAIT>0.
  - IDLE → RESP: on acceptance, when WAIT=0.
  - BUSY → RESP: after the wait counter expires.
  - RESP → IDLE, or RESP → BUSY/RESP: on back-to-back acceptance.
- A request is accepted at a rising edge where req=1 and ready=1. Address, wen and wdata are captured at that edge.
- ready = 1 in IDLE and in the RESP cycle; ready = 0 in BUSY.
- Read: rdata holds mem[index] as sampled at the completion edge.
- Write, when any d_wen bit is set:
  - Only the enabled bytes are updated, at the completion edge.
  - d_rdata returns the word's contents before the write (read-before-write).
  - d_valid pulses to acknowledge the write.
- Collision: an i-port read and a d-port write to the same word completing on the same edge → i_rdata returns the old word. The write still lands.
- req is ignored while ready=0. The requester must hold req and its operands until acceptance.
- rdata holds its last value when valid=0.
- Memory contents are not initialised or cleared by reset.

## Timing
- Accept at edge n. The completion edge is n+WAIT. valid=1 during the cycle after edge n+WAIT.
- WAIT=0: ready is constantly 1. One access per cycle per port. Data is available one cycle after the request, matching the existing registered memory.
- WAIT=W: the port accepts at most one access per W+1 cycles. The next acceptance can occur at edge n+W+1.
- Reset asserted, asynchronously:
  - i_valid = d_valid = 0.
  - i_rdata = d_rdata = 0.
  - i_ready = d_ready = 0.
  - d_err = 0.
  - FSMs go to IDLE and wait counters clear.
- First cycle after reset release: ready = 1.
- Reset during BUSY or RESP: the pending access is discarded, no write is committed, and no valid is produced.

## Configuration
- DPMEM_RANGE_CHECK_EN defined:
  - An index ≥ DEPTH (upper address bits non-zero) completes normally with valid.
  - The access returns rdata = 0 and suppresses the write.
  - d_err = 1 in the valid cycle. i-port range errors return 0 without a flag.
- DPMEM_RANGE_CHECK_EN undefined:
  - The index wraps modulo DEPTH, using the low address bits.
  - The d_err port is absent.

## Structure
- miniproc_pkg holds:
  - the port FSM state typedef (IDLE, BUSY, RESP);
  - the default DATA_W/ADDR_W constants;
  - a clog2-based index-width function.
- Sub-module mem_port_ctrl: handshake FSM, wait counter and capture registers. It is instantiated once per port.
- The top level holds the array, the byte-enable write logic and the collision ordering.

## Test plan
- WAIT=0, write 0xDEADBEEF with d_wen=4'hF at address 0x10, then read 0x10 on the i-port → i_valid one cycle after acceptance, i_rdata=0xDEADBEEF.
- Byte enables: address 0x10 holds 0xDEADBEEF; write 0x11223344 with d_wen=4'b0101 → a later read returns 0xDE22BE44, and the write's d_rdata=0xDEADBEEF.
- WAIT=3, back-to-back d-port reads held on req → valid every 4th cycle, ready low for 3 cycles after each acceptance.
- Collision: same-edge i-read and d-write of 0x55AA55AA to a word holding 0x0 → i_rdata=0x0; a next read returns 0x55AA55AA.
- Reset pulse while BUSY (WAIT=2) on a write → no valid, word unchanged; ready=1 on the first cycle after release.
- With DPMEM_RANGE_CHECK_EN, DEPTH=1024, write to 0x1000 → d_err=1, d_rdata=0, word 0 unchanged. Without the macro, the same write lands in word 0.
